// File: rtl/btn_mode_sel_pkg.sv
// Shared definitions for the button-driven mode selector.
// Holds the FSM state encoding, button bit positions and the wrapping
// mode-step helper used by the top level.
package btn_mode_sel_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_LWAIT = 2'd2
    } state_t;

    // Bit positions inside btn_deb
    localparam int BTN_NEXT = 0;
    localparam int BTN_PREV = 1;
    localparam int BTN_NUM  = 2;

    // Step a mode index by one with wrap-around inside 0..num-1.
    // up = 1 increments, up = 0 decrements.
    function automatic int mode_step(input int cur, input int num, input bit up);
        if (up) begin
            return (cur == num - 1) ? 0 : cur + 1;
        end
        return (cur == 0) ? num - 1 : cur - 1;
    endfunction

endpackage

// File: rtl/btn_mode_sel_edge.sv
// Purpose : per-bit press/release edge detector for active-high button levels.
// Latency : combinational outputs from the current level and a 1-cycle history.
// Backpr. : none; evaluated every cycle.
//
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   lvl        normalised button levels, 1 = pressed
//   press      1 in the cycle a bit goes 0 -> 1
//   rel        1 in the cycle a bit goes 1 -> 0
module btn_edge_det #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] lvl,
    output logic [W-1:0] press,
    output logic [W-1:0] rel
);

    logic [W-1:0] lvl_prev;

    // History resets to "pressed" so a button held through reset has to be
    // released before it can produce a press edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_prev <= '1;
        end else begin
            lvl_prev <= lvl;
        end
    end

    assign press = lvl & ~lvl_prev;
    assign rel   = ~lvl & lvl_prev;

endmodule

// File: rtl/btn_mode_sel.sv
// Purpose : turns debounced next/prev buttons into a wrapped mode index with event pulses.
// Latency : mode/mode_chg update 1 clk after the qualifying edge; long_evt LONG_CYC clks after press.
// Backpr. : none; consumers must take the one-cycle pulses when they occur.
//
// Ports:
//   clk       system clock (same domain as the debounce stage)
//   rst       asynchronous active-high reset
//   btn_deb   debounced levels; bit0 = next (short) / default (long), bit1 = previous
//   mode      current mode index, registered
//   mode_chg  1-cycle pulse when a mode action is accepted (incl. long press into DEFAULT_MODE)
//   long_evt  1-cycle pulse when a long press is recognised
//   busy      high while a button-0 press is being timed or waiting for release
//
// Parameter constraints: MODE_NUM >= 2, 2**MODE_W >= MODE_NUM,
// DEFAULT_MODE < MODE_NUM, LONG_CYC >= 2, 2**CNT_W > LONG_CYC.
module btn_mode_sel #(
    parameter int MODE_NUM       = 4,
    parameter int MODE_W         = 2,
    parameter int DEFAULT_MODE   = 0,
    parameter int LONG_CYC       = 12000000,
    parameter int CNT_W          = 24,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        btn_deb,
    output logic [MODE_W-1:0] mode,
    output logic              mode_chg,
    output logic              long_evt,
    output logic              busy
);

    import btn_mode_sel_pkg::*;

    localparam logic [1:0]        ACT_MASK  = (BTN_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;
    localparam logic [CNT_W-1:0]  LONG_LIM  = CNT_W'(LONG_CYC);
    localparam logic [CNT_W-1:0]  LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [MODE_W-1:0] MODE_DEF  = MODE_W'(DEFAULT_MODE);

    logic [1:0]       act;
    logic [1:0]       press;
    logic [1:0]       rel;
    logic             unused_rel;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Normalise polarity: act = 1 means pressed.
    assign act = btn_deb ^ ACT_MASK;

    btn_edge_det #(
        .W (BTN_NUM)
    ) u_edge (
        .clk   (clk),
        .rst   (rst),
        .lvl   (act),
        .press (press),
        .rel   (rel)
    );

    // Releasing "previous" carries no meaning.
    assign unused_rel = rel[BTN_PREV];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            mode     <= MODE_DEF;
            mode_chg <= 1'b0;
            long_evt <= 1'b0;
            busy     <= 1'b0;
        end else begin
            // Pulses are one cycle wide by construction.
            mode_chg <= 1'b0;
            long_evt <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    // Button 0 wins over a coincident button-1 press.
                    if (press[BTN_NEXT]) begin
                        state <= ST_HOLD;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end else if (press[BTN_PREV]) begin
                        mode     <= MODE_W'(mode_step(int'(mode), MODE_NUM, 1'b0));
                        mode_chg <= 1'b1;
                    end
                end

                ST_HOLD: begin
                    // Button 1 is ignored while button 0 is being timed.
                    if (rel[BTN_NEXT] && (cnt < LONG_LIM)) begin
                        mode     <= MODE_W'(mode_step(int'(mode), MODE_NUM, 1'b1));
                        mode_chg <= 1'b1;
                        state    <= ST_IDLE;
                        cnt      <= '0;
                        busy     <= 1'b0;
                    end else if ((cnt == LONG_LAST) && act[BTN_NEXT]) begin
                        // Leaving HOLD here keeps cnt from ever passing LONG_CYC-1.
                        mode     <= MODE_DEF;
                        mode_chg <= 1'b1;
                        long_evt <= 1'b1;
                        state    <= ST_LWAIT;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                ST_LWAIT: begin
                    // The release that ends a long press does not change mode.
                    if (rel[BTN_NEXT]) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_mode_sel.sv
// Bench for btn_mode_sel: directed scenarios with literal expectations plus
// randomized button activity, all checked every cycle against a timestamp-based
// reference model of the press rules.
module tb_btn_mode_sel;

    localparam int MODE_NUM  = 4;
    localparam int MODE_W    = 2;
    localparam int DEF_MODE  = 0;
    localparam int LONG_CYC  = 16;
    localparam int CNT_W     = 5;

    logic              clk;
    logic              rst;
    logic [1:0]        btn;
    logic [MODE_W-1:0] mode;
    logic              mode_chg;
    logic              long_evt;
    logic              busy;

    btn_mode_sel #(
        .MODE_NUM       (MODE_NUM),
        .MODE_W         (MODE_W),
        .DEFAULT_MODE   (DEF_MODE),
        .LONG_CYC       (LONG_CYC),
        .CNT_W          (CNT_W),
        .BTN_ACTIVE_LOW (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_deb  (btn),
        .mode     (mode),
        .mode_chg (mode_chg),
        .long_evt (long_evt),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a press of button 0 is remembered by its start
    // cycle; its duration decides short vs long. Pressed = input low.
    // ------------------------------------------------------------------
    int m_mode;
    bit m_chg, m_long, m_busy;
    bit was0, was1;          // pressed state seen at the previous edge
    bit timing;              // a button-0 press is outstanding
    bit long_done;           // that press already counted as long
    int start_cyc;
    int cyc = 0;
    bit a0, a1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode    = DEF_MODE;
            m_chg     = 1'b0;
            m_long    = 1'b0;
            m_busy    = 1'b0;
            was0      = 1'b1;
            was1      = 1'b1;
            timing    = 1'b0;
            long_done = 1'b0;
        end else begin
            cyc    = cyc + 1;
            a0     = (btn[0] == 1'b0);
            a1     = (btn[1] == 1'b0);
            m_chg  = 1'b0;
            m_long = 1'b0;
            if (!timing) begin
                if (a0 && !was0) begin
                    timing    = 1'b1;
                    long_done = 1'b0;
                    start_cyc = cyc;
                end else if (a1 && !was1) begin
                    m_mode = (m_mode + MODE_NUM - 1) % MODE_NUM;
                    m_chg  = 1'b1;
                end
            end else begin
                if (!a0) begin
                    if (!long_done) begin
                        m_mode = (m_mode + 1) % MODE_NUM;
                        m_chg  = 1'b1;
                    end
                    timing = 1'b0;
                end else if (!long_done && (cyc - start_cyc == LONG_CYC - 1)) begin
                    m_mode    = DEF_MODE;
                    m_chg     = 1'b1;
                    m_long    = 1'b1;
                    long_done = 1'b1;
                end
            end
            m_busy = timing;
            was0   = a0;
            was1   = a1;
        end
    end

    // Per-cycle comparison and pulse counting, just after each active edge.
    bit chk_en = 1'b0;
    int n_chg  = 0;
    int n_long = 0;

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("mdl_mode", int'(mode), m_mode);
            chk("mdl_mode_chg", int'(mode_chg), int'(m_chg));
            chk("mdl_long_evt", int'(long_evt), int'(m_long));
            chk("mdl_busy", int'(busy), int'(m_busy));
        end
        if (mode_chg === 1'b1) n_chg++;
        if (long_evt === 1'b1) n_long++;
    end

    // Hold button 0 pressed for n cycles, release, and step to the next
    // negedge, where the resulting mode_chg (if any) is visible.
    task automatic press_next(input int n);
        btn = 2'b10;
        repeat (n) @(negedge clk);
        btn = 2'b11;
        @(negedge clk);
    endtask

    int c0, l0, long_at, busy_low;

    initial begin
        rst = 1'b1;
        btn = 2'b11;

        // Reset with both buttons released
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_mode", int'(mode), 0);
        chk("rst_mode_chg", int'(mode_chg), 0);
        chk("rst_long_evt", int'(long_evt), 0);
        chk("rst_busy", int'(busy), 0);
        c0 = n_chg; l0 = n_long;
        repeat (10) @(negedge clk);
        chk("rst_quiet_chg", n_chg - c0, 0);
        chk("rst_quiet_long", n_long - l0, 0);

        // Four short presses: 1, 2, 3, 0
        c0 = n_chg; l0 = n_long;
        for (int k = 0; k < 4; k++) begin
            press_next(5);
            chk("short_chg_pulse", int'(mode_chg), 1);
            chk("short_mode", int'(mode), (k + 1) % MODE_NUM);
            repeat (3) @(negedge clk);
        end
        chk("short_chg_count", n_chg - c0, 4);
        chk("short_no_long", n_long - l0, 0);

        // Long press starting from mode 2
        press_next(5); repeat (3) @(negedge clk);
        press_next(5); repeat (3) @(negedge clk);
        chk("long_start_mode", int'(mode), 2);
        c0 = n_chg; l0 = n_long; long_at = 0; busy_low = 0;
        btn = 2'b10;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (long_evt) long_at = i;
            if (!busy) busy_low = 1;
        end
        chk("long_evt_cycle", long_at, 16);
        chk("long_evt_count", n_long - l0, 1);
        chk("long_chg_count", n_chg - c0, 1);
        chk("long_mode", int'(mode), 0);
        chk("long_busy_held", busy_low, 0);
        btn = 2'b11;
        repeat (3) @(negedge clk);
        chk("long_release_mode", int'(mode), 0);
        chk("long_release_busy", int'(busy), 0);
        chk("long_release_chg", n_chg - c0, 1);

        // Threshold: 15 cycles is short, 16 is long
        l0 = n_long;
        press_next(15);
        chk("thr15_chg", int'(mode_chg), 1);
        chk("thr15_mode", int'(mode), 1);
        chk("thr15_no_long", n_long - l0, 0);
        repeat (3) @(negedge clk);
        press_next(16);
        chk("thr16_long", n_long - l0, 1);
        chk("thr16_mode", int'(mode), 0);
        chk("thr16_release_chg", int'(mode_chg), 0);
        repeat (3) @(negedge clk);

        // Previous with wrap, then coincident press
        btn = 2'b01;
        @(negedge clk);
        chk("prev_wrap_mode", int'(mode), 3);
        chk("prev_wrap_chg", int'(mode_chg), 1);
        btn = 2'b11;
        repeat (3) @(negedge clk);
        c0 = n_chg;
        btn = 2'b00;
        repeat (5) @(negedge clk);
        chk("both_busy", int'(busy), 1);
        chk("both_no_chg", n_chg - c0, 0);
        btn = 2'b01;
        @(negedge clk);
        chk("both_short_mode", int'(mode), 0);
        repeat (3) @(negedge clk);
        btn = 2'b11;
        repeat (3) @(negedge clk);
        chk("both_btn1_ignored", n_chg - c0, 1);
        chk("both_final_mode", int'(mode), 0);

        // Reset in the middle of a hold
        press_next(5);
        repeat (3) @(negedge clk);
        chk("pre_rst_mode", int'(mode), 1);
        c0 = n_chg; l0 = n_long;
        btn = 2'b10;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_mode", int'(mode), 0);
        chk("midrst_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_held_busy", int'(busy), 0);
        chk("midrst_no_chg", n_chg - c0, 0);
        chk("midrst_no_long", n_long - l0, 0);
        btn = 2'b11;
        repeat (3) @(negedge clk);
        press_next(5);
        chk("midrst_after_mode", int'(mode), 1);
        repeat (3) @(negedge clk);

        // Randomized activity, checked by the model every cycle
        for (int r = 0; r < 300; r++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
            btn = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 24)) @(negedge clk);
        end
        btn = 2'b11;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/btn_mode_sel.md
Name: btn_mode_sel

Overview:
- Consumes the debounced button levels from the button debounce stage and turns them into a wrapped operating-mode index for the video-processing pipeline.
- Button 0 is "next mode" on a short press and "return to default mode" on a long press. Button 1 is "previous mode".
- Emits one-cycle event pulses so downstream mode muxes and OSD logic update exactly once per accepted action.

Parameters:
- MODE_NUM, 4, number of modes; index range 0..MODE_NUM-1; must be >= 2.
- MODE_W, 2, width of the mode index; must satisfy 2^MODE_W >= MODE_NUM.
- DEFAULT_MODE, 0, mode after reset and after a long press; must be < MODE_NUM.
- LONG_CYC, 12000000, hold length in clk cycles that makes a long press (1 s at 12 MHz); must be >= 2.
- CNT_W, 24, hold-counter width; must satisfy 2^CNT_W > LONG_CYC.
- BTN_ACTIVE_LOW, 1, 1 = button pressed when input is 0.

Ports:
- clk  input  1  system clock, 12 MHz; same domain as the debounce stage.
- rst  input  1  asynchronous, active-high reset.
- btn_deb  input  2  debounced, clk-synchronous button levels. Bit0 = next/default, bit1 = previous.
- mode  output  MODE_W  current mode index, registered.
- mode_chg  output  1  one-cycle pulse in the cycle `mode` takes a new value; also asserted when a long press re-selects DEFAULT_MODE while already in it.
- long_evt  output  1  one-cycle pulse when a long press is recognised.
- busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Clocking and reset:
  - Single clock, clk.
  - Reset is asynchronous and active-high, named rst. All flops clear on rst asynchronously.
- Reset values:
  - mode = DEFAULT_MODE; mode_chg = 0; long_evt = 0; busy = 0; FSM = IDLE; hold counter = 0.
  - Previous-level registers reset to the PRESSED state. A button held through reset must be released before it can generate a press.
- Level normalisation: `act[i] = btn_deb[i] XOR BTN_ACTIVE_LOW`, so 1 means pressed.
- Edge detect: `press[i] = act[i] & ~act_prev[i]` and `rel[i] = ~act[i] & act_prev[i]`, with `act_prev` registered every cycle.
- FSM states:
  - IDLE
    - If press[0]: go to HOLD, counter = 1. Button 0 has priority; a simultaneous press[1] is discarded.
    - Else if press[1]: mode = (mode == 0) ? MODE_NUM-1 : mode-1; mode_chg = 1; stay in IDLE.
  - HOLD
    - If rel[0] while counter < LONG_CYC: short press. mode = (mode == MODE_NUM-1) ? 0 : mode+1; mode_chg = 1; go to IDLE; counter = 0.
    - Else if counter == LONG_CYC-1 and act[0]: long press. mode = DEFAULT_MODE; mode_chg = 1; long_evt = 1; go to LWAIT.
    - Else: counter += 1.
    - press[1] is ignored in this state.
  - LWAIT
    - Wait for rel[0], then go to IDLE. No mode change on this release.
    - Button 1 is ignored.
- Latency:
  - Mode change: mode and mode_chg update on the clk edge after the cycle in which the qualifying rel/press edge is visible on btn_deb.
  - Long press: long_evt asserts in the cycle that is LONG_CYC cycles after the HOLD entry edge.
- Counter: saturates by construction and never wraps. It is cleared on every entry to IDLE.
- Pulse generation: mode_chg and long_evt are registered and default to 0 every cycle, so each is exactly one cycle wide.
- busy: asserted in HOLD and LWAIT, 0 in IDLE.
- Boundary conditions:
  - Wrap-around: next from MODE_NUM-1 gives 0; previous from 0 gives MODE_NUM-1.
  - Button 1 pressed while button 0 is held: ignored; a new button-1 edge is required after returning to IDLE.
  - Reset asserted mid-HOLD: immediate return to IDLE and DEFAULT_MODE, no pulses. Both buttons must then be released before they are recognised again.
  - Input is assumed already debounced; no internal filtering.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE = 2'd0, HOLD = 2'd1, LWAIT = 2'd2.
  - Button index constants: BTN_NEXT = 0, BTN_PREV = 1.
- One sub-module is natural: btn_edge_det, parameterised width, producing press/rel vectors with the reset-to-pressed previous state. It is instantiated once with width 2.

Test Plan (sim uses LONG_CYC = 16, MODE_NUM = 4, DEFAULT_MODE = 0, active-low):
- Reset check: hold rst 3 cycles with both buttons high, then release -> mode = 0; mode_chg, long_evt, busy all 0; no pulse for 10 cycles.
- Short-press sequence: btn0 low 5 cycles then high, repeated 4 times -> mode steps 1, 2, 3, 0. Exactly one mode_chg per press, one cycle after each rising edge of btn0; long_evt never asserts.
- Long press: starting at mode 2, hold btn0 low 40 cycles -> long_evt and mode_chg pulse once, 16 cycles after the press edge; mode = 0; busy high until release; no change on release.
- Long-press threshold boundary: release btn0 after exactly 15 cycles of being low -> increment (short press). Hold for 16 cycles -> long press.
- Previous and wrap: from mode 0, single btn1 pulse -> mode = 3 with one mode_chg. Btn0 and btn1 fall in the same cycle -> only the btn0 path runs; a later short release gives mode 0, and btn1 causes no change.
- Reset mid-operation: assert rst 8 cycles into a btn0 hold, keep btn0 low through reset -> mode = 0, no pulses. Release and re-press btn0 -> normal short press gives mode 1.
